// File: rtl/id_stage_hz.sv
// Decode stage: field decode, branch resolve, RAW hazard bubbles.
// Owns the ID/EXE register (ex_*) and a saturating stall counter.
module id_stage_hz #(
  parameter int DW     = 32,
  parameter int FWD_EN = 0,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             id_valid,
  input  logic [DW-1:0]    reg1,
  input  logic [DW-1:0]    reg2,
  input  logic             is_imm,
  input  logic             st_or_bne,
  input  logic             mem_r_en,
  input  logic             mem_w_en,
  input  logic             wb_en,
  input  logic [1:0]       br_type,
  input  logic [3:0]       exe_cmd,
  input  logic [4:0]       exe_dest,
  input  logic [4:0]       mem_dest,
  input  logic             exe_wb_en,
  input  logic             mem_wb_en,
  input  logic             exe_mem_r_en,
  input  logic             freeze,
  input  logic             flush,
  output logic [4:0]       src1,
  output logic [4:0]       src2,
  output logic             stall,
  output logic             br_taken,
  output logic [DW-1:0]    br_offset,
  output logic             ex_valid,
  output logic             ex_wb_en,
  output logic             ex_mem_r_en,
  output logic             ex_mem_w_en,
  output logic [3:0]       ex_cmd,
  output logic [4:0]       ex_dest,
  output logic [DW-1:0]    ex_val1,
  output logic [DW-1:0]    ex_val2,
  output logic [DW-1:0]    ex_reg2,
  output logic [4:0]       ex_src1,
  output logic [4:0]       ex_src2,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic          valid;
    logic          wb_en;
    logic          mem_r_en;
    logic          mem_w_en;
    logic [3:0]    cmd;
    logic [4:0]    dest;
    logic [DW-1:0] val1;
    logic [DW-1:0] val2;
    logic [DW-1:0] reg2;
    logic [4:0]    src1;
    logic [4:0]    src2;
  } id_ex_t;

  id_ex_t           ex_q, ex_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [4:0]    dest;
  logic [DW-1:0] imm;
  logic [DW-1:0] val2;
  logic          uses_src2;
  logic          hz_e, hz_m;
  logic          cond;
  logic          unused_ok;

  assign unused_ok = ^instr[31:26];

  assign src1 = instr[20:16];
  assign src2 = st_or_bne ? instr[25:21]
                          : instr[15:11];
  assign dest = instr[25:21];
  assign imm  = DW'(signed'(instr[15:0]));
  assign val2 = is_imm ? imm : reg2;

  // A jump reads no second operand.
  assign uses_src2 = (~is_imm | st_or_bne)
                   & (br_type != 2'b11);

  assign hz_e = exe_wb_en & (exe_dest != 5'd0)
              & ((exe_dest == src1)
              | (uses_src2 & (exe_dest == src2)));

  assign hz_m = mem_wb_en & (mem_dest != 5'd0)
              & ((mem_dest == src1)
              | (uses_src2 & (mem_dest == src2)));

  // With forwarding only a load in EXE is
  // too late to bypass.
  assign stall = id_valid
               & ((FWD_EN != 0)
                  ? (hz_e & exe_mem_r_en)
                  : (hz_e | hz_m));

  always_comb begin
    cond = 1'b0;
    unique case (br_type)
      2'b01:   cond = (reg1 == '0);
      2'b10:   cond = (reg1 != reg2);
      2'b11:   cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

  assign br_taken  = id_valid & ~stall & ~freeze
                   & ~flush & cond;
  assign br_offset = imm;

  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (freeze) begin
      ex_d  = ex_q;
    end else if (flush) begin
      ex_d  = '0;
    end else if (stall) begin
      ex_d  = '0;
      if (cnt_q != '1)
        cnt_d = cnt_q + CNT_W'(1);
    end else begin
      ex_d.valid    = id_valid;
      ex_d.wb_en    = wb_en & id_valid;
      ex_d.mem_r_en = mem_r_en & id_valid;
      ex_d.mem_w_en = mem_w_en & id_valid;
      ex_d.cmd      = exe_cmd;
      ex_d.dest     = dest;
      ex_d.val1     = reg1;
      ex_d.val2     = val2;
      ex_d.reg2     = reg2;
      ex_d.src1     = src1;
      ex_d.src2     = src2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign ex_valid    = ex_q.valid;
  assign ex_wb_en    = ex_q.wb_en;
  assign ex_mem_r_en = ex_q.mem_r_en;
  assign ex_mem_w_en = ex_q.mem_w_en;
  assign ex_cmd      = ex_q.cmd;
  assign ex_dest     = ex_q.dest;
  assign ex_val1     = ex_q.val1;
  assign ex_val2     = ex_q.val2;
  assign ex_reg2     = ex_q.reg2;
  assign ex_src1     = ex_q.src1;
  assign ex_src2     = ex_q.src2;
  assign stall_cnt   = cnt_q;

endmodule

// File: tb/tb_id_stage_hz.sv
// Bench for id_stage_hz: two instances (A: DW32/stall-all/CNT16,
// B: DW16/load-use/CNT2), directed table, sequences, random.
module tb_id_stage_hz;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        id_valid;
  logic [31:0] reg1, reg2;
  logic        is_imm, st_or_bne, mem_r_en, mem_w_en, wb_en;
  logic [1:0]  br_type;
  logic [3:0]  exe_cmd;
  logic [4:0]  exe_dest, mem_dest;
  logic        exe_wb_en, mem_wb_en, exe_mem_r_en;
  logic        freeze, flush;

  logic [4:0]  a_s1, a_s2, a_xs1, a_xs2, a_dest;
  logic        a_st, a_br, a_v, a_wb, a_mr, a_mw;
  logic [31:0] a_off, a_v1, a_v2, a_r2;
  logic [3:0]  a_cmd;
  logic [15:0] a_cnt;

  logic [4:0]  b_s1, b_s2, b_xs1, b_xs2, b_dest;
  logic        b_st, b_br, b_v, b_wb, b_mr, b_mw;
  logic [15:0] b_off, b_v1, b_v2, b_r2;
  logic [3:0]  b_cmd;
  logic [1:0]  b_cnt;

  always #5 clk = ~clk;

  id_stage_hz dA (
    .clk(clk), .rst(rst), .instr(instr), .id_valid(id_valid),
    .reg1(reg1), .reg2(reg2), .is_imm(is_imm),
    .st_or_bne(st_or_bne), .mem_r_en(mem_r_en),
    .mem_w_en(mem_w_en), .wb_en(wb_en), .br_type(br_type),
    .exe_cmd(exe_cmd), .exe_dest(exe_dest), .mem_dest(mem_dest),
    .exe_wb_en(exe_wb_en), .mem_wb_en(mem_wb_en),
    .exe_mem_r_en(exe_mem_r_en), .freeze(freeze), .flush(flush),
    .src1(a_s1), .src2(a_s2), .stall(a_st), .br_taken(a_br),
    .br_offset(a_off), .ex_valid(a_v), .ex_wb_en(a_wb),
    .ex_mem_r_en(a_mr), .ex_mem_w_en(a_mw), .ex_cmd(a_cmd),
    .ex_dest(a_dest), .ex_val1(a_v1), .ex_val2(a_v2),
    .ex_reg2(a_r2), .ex_src1(a_xs1), .ex_src2(a_xs2),
    .stall_cnt(a_cnt)
  );

  id_stage_hz #(.DW(16), .FWD_EN(1), .CNT_W(2)) dB (
    .clk(clk), .rst(rst), .instr(instr), .id_valid(id_valid),
    .reg1(reg1[15:0]), .reg2(reg2[15:0]), .is_imm(is_imm),
    .st_or_bne(st_or_bne), .mem_r_en(mem_r_en),
    .mem_w_en(mem_w_en), .wb_en(wb_en), .br_type(br_type),
    .exe_cmd(exe_cmd), .exe_dest(exe_dest), .mem_dest(mem_dest),
    .exe_wb_en(exe_wb_en), .mem_wb_en(mem_wb_en),
    .exe_mem_r_en(exe_mem_r_en), .freeze(freeze), .flush(flush),
    .src1(b_s1), .src2(b_s2), .stall(b_st), .br_taken(b_br),
    .br_offset(b_off), .ex_valid(b_v), .ex_wb_en(b_wb),
    .ex_mem_r_en(b_mr), .ex_mem_w_en(b_mw), .ex_cmd(b_cmd),
    .ex_dest(b_dest), .ex_val1(b_v1), .ex_val2(b_v2),
    .ex_reg2(b_r2), .ex_src1(b_xs1), .ex_src2(b_xs2),
    .stall_cnt(b_cnt)
  );

  typedef struct {
    bit        v, wb, mr, mw;
    bit [3:0]  cmd;
    bit [4:0]  dest, s1, s2;
    bit [31:0] v1, v2, r2;
    int        cnt;
  } ex_t;

  typedef struct {
    bit [31:0] ins;
    bit        v, imm, sob;
    bit [1:0]  bt;
    bit [31:0] r1, r2;
    bit [4:0]  ed, md;
    bit        ewb, mwb, emr, frz, fl;
    bit        xsa, xsb, xbr;
  } vec_t;

  ex_t eA, eB;
  int  nvec = 0;
  int  nfail = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit [31:0] mk(bit [4:0] d, bit [4:0] s,
                                   bit [4:0] rt, bit [10:0] lo);
    return {6'd0, d, s, rt, lo};
  endfunction

  // Reference: decode rules computed from the fields directly.
  function automatic void mcomb(input int dw, input bit fwd,
                                output bit st, output bit br,
                                output bit [31:0] off,
                                output bit [4:0] s1,
                                output bit [4:0] s2);
    bit [31:0] m;
    bit        two, he, hm, cond;
    int        sx;
    m    = (dw == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    s1   = instr[20:16];
    s2   = st_or_bne ? instr[25:21] : instr[15:11];
    two  = (!is_imm || st_or_bne) && br_type != 2'd3;
    he   = exe_wb_en && exe_dest != 0
        && (exe_dest == s1 || (two && exe_dest == s2));
    hm   = mem_wb_en && mem_dest != 0
        && (mem_dest == s1 || (two && mem_dest == s2));
    st   = id_valid && (fwd ? (he && exe_mem_r_en) : (he || hm));
    case (br_type)
      2'd1:    cond = (reg1 & m) == 0;
      2'd2:    cond = (reg1 & m) != (reg2 & m);
      2'd3:    cond = 1;
      default: cond = 0;
    endcase
    br   = id_valid && !st && !freeze && !flush && cond;
    sx   = instr[15] ? int'(instr[15:0]) - 65536 : int'(instr[15:0]);
    off  = 32'(sx) & m;
  endfunction

  function automatic ex_t mseq(ex_t e, int dw, bit fwd, int cmax);
    ex_t       n;
    bit        st, br;
    bit [31:0] off, m;
    bit [4:0]  s1, s2;
    m = (dw == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    mcomb(dw, fwd, st, br, off, s1, s2);
    n = '{default: 0};
    if (freeze) return e;
    if (flush) begin
      n.cnt = e.cnt;
    end else if (st) begin
      n.cnt = (e.cnt < cmax) ? e.cnt + 1 : e.cnt;
    end else begin
      n.cnt  = e.cnt;
      n.v    = id_valid;
      n.wb   = wb_en && id_valid;
      n.mr   = mem_r_en && id_valid;
      n.mw   = mem_w_en && id_valid;
      n.cmd  = exe_cmd;
      n.dest = instr[25:21];
      n.v1   = reg1 & m;
      n.v2   = is_imm ? off : (reg2 & m);
      n.r2   = reg2 & m;
      n.s1   = s1;
      n.s2   = s2;
    end
    return n;
  endfunction

  task automatic chk_regs();
    chk("A.ex_valid", 32'(a_v), 32'(eA.v));
    chk("A.ex_wb_en", 32'(a_wb), 32'(eA.wb));
    chk("A.ex_mem_r_en", 32'(a_mr), 32'(eA.mr));
    chk("A.ex_mem_w_en", 32'(a_mw), 32'(eA.mw));
    chk("A.ex_cmd", 32'(a_cmd), 32'(eA.cmd));
    chk("A.ex_dest", 32'(a_dest), 32'(eA.dest));
    chk("A.ex_val1", a_v1, eA.v1);
    chk("A.ex_val2", a_v2, eA.v2);
    chk("A.ex_reg2", a_r2, eA.r2);
    chk("A.ex_src1", 32'(a_xs1), 32'(eA.s1));
    chk("A.ex_src2", 32'(a_xs2), 32'(eA.s2));
    chk("A.stall_cnt", 32'(a_cnt), 32'(eA.cnt));
    chk("B.ex_valid", 32'(b_v), 32'(eB.v));
    chk("B.ex_wb_en", 32'(b_wb), 32'(eB.wb));
    chk("B.ex_mem_r_en", 32'(b_mr), 32'(eB.mr));
    chk("B.ex_mem_w_en", 32'(b_mw), 32'(eB.mw));
    chk("B.ex_cmd", 32'(b_cmd), 32'(eB.cmd));
    chk("B.ex_dest", 32'(b_dest), 32'(eB.dest));
    chk("B.ex_val1", 32'(b_v1), eB.v1);
    chk("B.ex_val2", 32'(b_v2), eB.v2);
    chk("B.ex_reg2", 32'(b_r2), eB.r2);
    chk("B.ex_src1", 32'(b_xs1), 32'(eB.s1));
    chk("B.ex_src2", 32'(b_xs2), 32'(eB.s2));
    chk("B.stall_cnt", 32'(b_cnt), 32'(eB.cnt));
  endtask

  // Inputs must already be driven; checks comb, clocks, checks regs.
  task automatic step();
    bit        st, br;
    bit [31:0] off;
    bit [4:0]  s1, s2;
    #1;
    mcomb(32, 0, st, br, off, s1, s2);
    chk("A.stall", 32'(a_st), 32'(st));
    chk("A.br_taken", 32'(a_br), 32'(br));
    chk("A.br_offset", a_off, off);
    chk("A.src1", 32'(a_s1), 32'(s1));
    chk("A.src2", 32'(a_s2), 32'(s2));
    mcomb(16, 1, st, br, off, s1, s2);
    chk("B.stall", 32'(b_st), 32'(st));
    chk("B.br_taken", 32'(b_br), 32'(br));
    chk("B.br_offset", 32'(b_off), off);
    @(posedge clk);
    eA = mseq(eA, 32, 0, 65535);
    eB = mseq(eB, 16, 1, 3);
    #1;
    chk_regs();
  endtask

  task automatic idle();
    instr = 0; id_valid = 0; reg1 = 0; reg2 = 0; is_imm = 0;
    st_or_bne = 0; mem_r_en = 0; mem_w_en = 0; wb_en = 0;
    br_type = 0; exe_cmd = 0; exe_dest = 0; mem_dest = 0;
    exe_wb_en = 0; mem_wb_en = 0; exe_mem_r_en = 0;
    freeze = 0; flush = 0;
  endtask

  task automatic do_reset();
    rst = 0;
    #1;
    eA = '{default: 0};
    eB = '{default: 0};
    @(negedge clk);
    rst = 1;
  endtask

  // Stall-causing inputs for both instances: load in EXE writing r5.
  task automatic set_loaduse();
    idle();
    instr = mk(5'd1, 5'd5, 5'd2, 11'd0);
    id_valid = 1; is_imm = 1; wb_en = 1;
    exe_dest = 5; exe_wb_en = 1; exe_mem_r_en = 1;
  endtask

  vec_t tbl[$];
  vec_t t;
  int   cA[5] = '{1, 2, 3, 4, 5};
  int   cB[5] = '{1, 2, 3, 3, 3};

  initial begin
    idle();
    rst = 0;
    eA = '{default: 0};
    eB = '{default: 0};
    repeat (2) @(posedge clk);
    #1;
    chk_regs();
    @(negedge clk);
    rst = 1;

    //          ins                 v imm sob bt r1 r2 ed md ewb mwb emr frz fl  A B br
    tbl.push_back('{mk(1,5,2,0), 1,1,0,0, 1,1, 5,0, 1,0,0,0,0, 1,0,0});
    tbl.push_back('{mk(1,5,2,0), 1,1,0,0, 1,1, 5,0, 1,0,1,0,0, 1,1,0});
    tbl.push_back('{mk(1,0,2,0), 1,1,0,0, 1,1, 5,0, 1,0,1,0,0, 0,0,0});
    tbl.push_back('{mk(1,0,0,0), 1,0,0,0, 1,1, 0,0, 1,0,1,0,0, 0,0,0});
    tbl.push_back('{mk(3,1,0,0), 1,0,1,2, 3,3, 0,0, 0,0,0,0,0, 0,0,0});
    tbl.push_back('{mk(3,1,0,0), 1,0,1,2, 3,4, 0,0, 0,0,0,0,0, 0,0,1});
    tbl.push_back('{mk(3,1,0,0), 1,0,1,1, 0,4, 0,0, 0,0,0,0,0, 0,0,1});
    tbl.push_back('{mk(3,1,0,0), 1,0,1,1, 0,4, 0,0, 0,0,0,1,0, 0,0,0});
    tbl.push_back('{mk(1,1,7,0), 1,0,0,3, 1,1, 7,0, 1,0,1,0,0, 0,0,1});
    tbl.push_back('{mk(1,1,7,0), 1,0,0,0, 1,1, 7,0, 1,0,1,0,0, 1,1,0});
    tbl.push_back('{mk(1,9,2,0), 1,1,0,0, 1,1, 0,9, 0,1,0,0,0, 1,0,0});
    tbl.push_back('{mk(1,7,0,0), 0,1,0,3, 1,1, 7,0, 1,0,1,0,0, 0,0,0});
    tbl.push_back('{mk(1,5,0,0), 1,1,0,3, 1,1, 5,0, 1,0,1,0,1, 1,1,0});
    tbl.push_back('{mk(6,1,0,0), 1,1,1,2, 1,2, 6,0, 1,0,0,0,0, 1,0,0});

    @(posedge clk);
    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      t = tbl[i];
      instr = t.ins; id_valid = t.v; is_imm = t.imm;
      st_or_bne = t.sob; br_type = t.bt; reg1 = t.r1; reg2 = t.r2;
      exe_dest = t.ed; mem_dest = t.md; exe_wb_en = t.ewb;
      mem_wb_en = t.mwb; exe_mem_r_en = t.emr;
      freeze = t.frz; flush = t.fl;
      wb_en = 1; mem_r_en = i[0]; mem_w_en = i[1]; exe_cmd = i[3:0];
      #1;
      chk($sformatf("tbl%0d.A.stall", i), 32'(a_st), 32'(t.xsa));
      chk($sformatf("tbl%0d.B.stall", i), 32'(b_st), 32'(t.xsb));
      chk($sformatf("tbl%0d.A.br", i), 32'(a_br), 32'(t.xbr));
      step();
    end

    // Immediate sign extension at both widths.
    idle();
    instr = mk(5'd2, 5'd3, 5'd31, 11'h7FE);
    id_valid = 1; is_imm = 1; wb_en = 1;
    step();
    chk("imm.A.ex_val2", a_v2, 32'hFFFF_FFFE);
    chk("imm.B.ex_val2", 32'(b_v2), 32'h0000_FFFE);

    // Load then freeze with a different instruction.
    idle();
    instr = mk(5'd4, 5'd6, 5'd7, 11'd0);
    id_valid = 1; wb_en = 1; reg1 = 32'h1234_5678; reg2 = 32'h0000_0042;
    step();
    chk("load.A.ex_val1", a_v1, 32'h1234_5678);
    instr = mk(5'd9, 5'd10, 5'd11, 11'd0);
    reg1 = 32'hDEAD_BEEF; freeze = 1;
    step();
    chk("frz.A.ex_val1", a_v1, 32'h1234_5678);
    chk("frz.A.ex_dest", 32'(a_dest), 32'd4);
    chk("frz.A.ex_wb_en", 32'(a_wb), 32'd1);

    // Counter saturation from a clean reset.
    do_reset();
    set_loaduse();
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("sat%0d.A.cnt", i), 32'(a_cnt), 32'(cA[i]));
      chk($sformatf("sat%0d.B.cnt", i), 32'(b_cnt), 32'(cB[i]));
      chk($sformatf("sat%0d.A.valid", i), 32'(a_v), 32'd0);
    end
    freeze = 1;
    step();
    chk("frz.B.cnt", 32'(b_cnt), 32'd3);
    chk("frz.A.cnt", 32'(a_cnt), 32'd5);

    // Flush beats stall; counter holds.
    freeze = 0; flush = 1;
    step();
    chk("flush.A.cnt", 32'(a_cnt), 32'd5);

    // Async reset mid-operation with a write-back in ID/EXE.
    idle();
    instr = mk(5'd3, 5'd1, 5'd2, 11'd0);
    id_valid = 1; wb_en = 1; reg1 = 32'h55;
    step();
    chk("pre_rst.A.ex_wb_en", 32'(a_wb), 32'd1);
    #1;
    rst = 0;
    #1;
    eA = '{default: 0};
    eB = '{default: 0};
    chk("rst.A.ex_wb_en", 32'(a_wb), 32'd0);
    chk("rst.A.ex_valid", 32'(a_v), 32'd0);
    chk("rst.A.ex_val1", a_v1, 32'd0);
    chk_regs();

    // Release during a stall: first edge evaluates normally.
    set_loaduse();
    @(posedge clk);
    @(negedge clk);
    rst = 1;
    step();
    chk("rel.A.cnt", 32'(a_cnt), 32'd1);
    chk("rel.B.cnt", 32'(b_cnt), 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      instr = $urandom;
      instr[25:21] = 5'($urandom_range(0, 3));
      instr[20:16] = 5'($urandom_range(0, 3));
      instr[15:11] = 5'($urandom_range(0, 3));
      id_valid = ($urandom % 6) != 0;
      reg1 = ($urandom % 4 == 0) ? 32'd0 : $urandom;
      reg2 = ($urandom % 3 == 0) ? reg1 : $urandom;
      is_imm = 1'($urandom); st_or_bne = 1'($urandom);
      mem_r_en = 1'($urandom); mem_w_en = 1'($urandom);
      wb_en = 1'($urandom); br_type = 2'($urandom);
      exe_cmd = 4'($urandom);
      exe_dest = 5'($urandom_range(0, 3));
      mem_dest = 5'($urandom_range(0, 3));
      exe_wb_en = 1'($urandom); mem_wb_en = 1'($urandom);
      exe_mem_r_en = 1'($urandom);
      freeze = ($urandom % 8) == 0;
      flush = ($urandom % 8) == 0;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/id_stage_hz.md
Name: id_stage_hz

Overview:
- Parametrised successor to the single-cycle decode stage, sitting between the IF/ID register and the EXE stage.
- Decodes register fields, sign-extends the immediate and selects Val2.
- Resolves branches with a 2-bit mode: none, BEZ, BNE, JMP.
- Detects RAW hazards against the EXE and MEM stages, inserts bubbles, and owns the registered ID/EXE pipeline register with a valid bit and a saturating stall counter.

Parameters:
- DW, 32, datapath width for Val1, Val2 and Reg2; the immediate is sign-extended from 16 to DW bits.
- FWD_EN, 0, 1 = forwarding exists downstream, so stall only on load-use; 0 = stall on any RAW match.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- instr  in  32  instruction from IF/ID
- id_valid  in  1  instr is valid
- reg1, reg2  in  DW  register-file read data for src1, src2
- is_imm, st_or_bne, mem_r_en, mem_w_en, wb_en  in  1  control-unit signals
- br_type  in  2  00 none, 01 BEZ, 10 BNE, 11 JMP
- exe_cmd  in  4  ALU command
- exe_dest, mem_dest  in  5  destination register of the instruction in EXE / MEM
- exe_wb_en, mem_wb_en, exe_mem_r_en  in  1  status of the EXE / MEM instruction
- freeze  in  1  global pipeline hold
- flush  in  1  squash the instruction entering ID/EXE
- src1, src2  out  5  combinational; drive the register-file read addresses
- stall  out  1  combinational; freezes PC and IF/ID
- br_taken  out  1  combinational
- br_offset  out  DW  combinational sign-extended immediate
- ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en  out  1  registered
- ex_cmd  out  4  registered
- ex_dest  out  5  registered
- ex_val1, ex_val2, ex_reg2  out  DW  registered
- ex_src1, ex_src2  out  5  registered, for the forwarding unit
- stall_cnt  out  CNT_W  registered

Behaviour:
- Field decode:
  - src1 = instr[20:16].
  - src2 = st_or_bne ? instr[25:21] : instr[15:11].
  - dest = instr[25:21].
  - imm = sign-extend(instr[15:0]) to DW.
  - val2 = is_imm ? imm : reg2.
- uses_src2 = ~is_imm | st_or_bne. Register 0 never hazards.
- Hazard:
  - hz_e = exe_wb_en & (exe_dest != 0) & ((exe_dest == src1) | (uses_src2 & exe_dest == src2)).
  - hz_m = the same form, using mem_dest and mem_wb_en.
  - FWD_EN=0: stall = id_valid & (hz_e | hz_m).
  - FWD_EN=1: stall = id_valid & hz_e & exe_mem_r_en.
- Branch:
  - cond: BEZ = (reg1 == 0); BNE = (reg1 != reg2); JMP = 1; none = 0.
  - br_taken = id_valid & ~stall & ~freeze & ~flush & cond.
  - JMP never stalls on src2: uses_src2 is forced to 0 when br_type = 11.
- ID/EXE register update priority, evaluated each rising clk edge:
  1. rst low (async, immediate): all registered outputs clear to 0.
  2. freeze: hold every registered output, including stall_cnt.
  3. flush: insert a bubble.
  4. stall: insert a bubble, and stall_cnt increments.
  5. otherwise: load the decoded values; ex_valid = id_valid.
- A bubble means ex_valid, ex_wb_en, ex_mem_r_en and ex_mem_w_en are 0; data fields may take any value but must be deterministic (load 0).
- Control outputs are ANDed with id_valid on load, so an invalid instr never writes back.
- stall_cnt increments only on cycles where stall=1 and freeze=0, and saturates at all-ones (no wrap).
- Latency: one cycle from instr to ex_* outputs.
- Reset deasserting mid-stall: the first edge after release evaluates normally; no bubble is retained.
- flush and stall together: flush wins and stall_cnt does not increment. The stall output remains asserted combinationally.

Test Plan:
1. Reset: drive rst=0 mid-operation with ex_wb_en=1 -> all ex_* and stall_cnt read 0 immediately, without waiting for a clk edge.
2. RAW, FWD_EN=0: exe_wb_en=1, exe_dest=5; instr has src1=5 with id_valid=1 -> stall=1; next edge ex_valid=0, ex_wb_en=0, stall_cnt=1. Repeat with src1=0 -> stall=0.
3. Load-use, FWD_EN=1: same setup with exe_mem_r_en=0 -> stall=0. With exe_mem_r_en=1 -> stall=1.
4. Branch: BNE with reg1=3, reg2=3 -> br_taken=0. BNE with reg2=4 -> br_taken=1. BEZ with reg1=0 -> br_taken=1. Same inputs plus freeze=1 -> br_taken=0.
5. Immediate: is_imm=1, instr[15:0]=16'hFFFE -> next edge ex_val2 = 32'hFFFFFFFE. Same with DW=16 -> 16'hFFFE.
6. Freeze/saturation: CNT_W=2 with stall held for 5 cycles -> stall_cnt goes 1, 2, 3, 3, 3. freeze=1 with a new instr -> ex_* unchanged.
